// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU load/store port: word RAM with RISC-V lane
// select/extension, fixed-latency stall handshake. Optional DMEM_ACCESS_COUNT_EN adds access counters.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemReq,
  input  logic        MemWE,
  input  logic [2:0]  MemSize,
  input  logic [31:0] MemA,
  input  logic [31:0] MemWD,
  output logic [31:0] MemRD,
  output logic        MemStall,
  output logic        MemError
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] RdCount,
  output logic [31:0] WrCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic              r_we;
  logic [2:0]        r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wd;
  logic              r_err;
  logic              w_accept;
  logic              w_commit;
  logic              w_err_in;
  logic [31:0]       w_word;
  logic [31:0]       r_ram [0:(1<<ADDR_W)-1];

  // Rejection is decided once, from the raw request, and carried to RESP.
  function automatic logic f_reject(input logic we, input logic [2:0] size,
                                    input logic [31:0] addr);
    logic rej;
    case (size)
      3'd0, 3'd4: rej = 1'b0;
      3'd1, 3'd5: rej = addr[0];
      3'd2:       rej = (addr[1:0] != 2'd0);
      default:    rej = 1'b1;
    endcase
    if (we && size[2]) rej = 1'b1;
    if (addr[31:ADDR_W+2] != '0) rej = 1'b1;
    return rej;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] size, input logic [1:0] lane,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [1:0] size, input logic [1:0] lane,
                                          input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    case (size)
      2'd0: begin
        case (lane)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      2'd1: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign w_err_in = f_reject(MemWE, MemSize, MemA);
  assign w_word   = r_ram[r_addr[ADDR_W+1:2]];
  assign w_commit = (r_state == S_RESP) && r_we && !r_err;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= '0;
      r_wd    <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we   <= MemWE;
        r_size <= MemSize;
        r_addr <= MemA[ADDR_W+1:0];
        r_wd   <= MemWD;
        r_err  <= w_err_in;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    MemStall   = 1'b0;
    MemError   = 1'b0;
    MemRD      = 32'd0;
    case (r_state)
      S_IDLE: begin
        MemStall = MemReq;
        if (MemReq) begin
          w_accept   = 1'b1;
          w_cnt_next = 4'(LATENCY - 1);
          w_next     = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        MemStall   = 1'b1;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        w_next   = S_IDLE;
        MemError = r_err;
        if (!r_we && !r_err) MemRD = f_load(r_size, r_addr[1:0], w_word);
      end
      default: w_next = S_IDLE;
    endcase
    // The CPU must be free to run while reset is held, even with MemReq high.
    if (!RESET) MemStall = 1'b0;
  end

  // RAM is never reset; a store only lands on the edge that leaves RESP.
  always_ff @(posedge CLK) begin
    if (w_commit)
      r_ram[r_addr[ADDR_W+1:2]] <= f_merge(r_size[1:0], r_addr[1:0], w_word, r_wd);
  end

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RdCount <= 32'd0;
      WrCount <= 32'd0;
    end else if (r_state == S_RESP && !r_err) begin
      if (r_we) WrCount <= WrCount + 32'd1;
      else      RdCount <= RdCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed plan cases plus randomized
// accesses checked against a byte-addressed memory model.
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MemReq = 1'b0;
  logic        MemWE = 1'b0;
  logic [2:0]  MemSize = 3'd0;
  logic [31:0] MemA = 32'd0;
  logic [31:0] MemWD = 32'd0;
  logic [31:0] MemRD;
  logic        MemStall;
  logic        MemError;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] RdCount, WrCount;
`endif

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic [7:0] mdl [0:63];

  data_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .MemReq(MemReq), .MemWE(MemWE), .MemSize(MemSize),
    .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD), .MemStall(MemStall), .MemError(MemError)
`ifdef DMEM_ACCESS_COUNT_EN
    , .RdCount(RdCount), .WrCount(WrCount)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_err(input bit we, input bit [2:0] size, input bit [31:0] a);
    if (a >= 32'h1000) return 1;
    if (size == 3 || size >= 6) return 1;
    if (we && (size == 4 || size == 5)) return 1;
    if ((size == 1 || size == 5) && (a % 2 != 0)) return 1;
    if (size == 2 && (a % 4 != 0)) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_load(input bit [2:0] size, input bit [31:0] a);
    int i;
    logic [7:0] b;
    logic [15:0] h;
    i = int'(a[5:0]);
    b = mdl[i];
    h = {mdl[(i + 1) % 64], mdl[i]};
    case (size)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'd0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return {mdl[(i + 3) % 64], mdl[(i + 2) % 64], mdl[(i + 1) % 64], mdl[i]};
    endcase
  endfunction

  task automatic model_commit(input bit we, input bit [2:0] size, input bit [31:0] a,
                              input bit [31:0] wd);
    int i;
    i = int'(a[5:0]);
    if (exp_err(we, size, a)) return;
    if (!we) begin
      n_rd++;
      return;
    end
    n_wr++;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || (k == 1 && size != 0) || size == 2)
        mdl[(i + k) % 64] = wd[8*k +: 8];
    end
  endtask

  // One CPU access; leak flags any non-zero MemRD/MemError while stalled.
  task automatic access(input bit we, input bit [2:0] size, input bit [31:0] a,
                        input bit [31:0] wd, input bit drop, output bit [31:0] rd,
                        output bit err, output int st, output bit leak);
    @(negedge CLK);
    MemReq = 1'b1; MemWE = we; MemSize = size; MemA = a; MemWD = wd;
    #1;
    st = 0;
    leak = 0;
    while (MemStall === 1'b1 && st < 40) begin
      if (MemRD !== 32'd0 || MemError !== 1'b0) leak = 1;
      st++;
      @(negedge CLK);
      #1;
    end
    if (st >= 40) begin
      checks++; errors++;
      $display("FAIL stall_timeout actual=%0d cycles required=%0d", st, LAT);
    end
    rd = MemRD;
    err = MemError;
    if (drop) MemReq = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    MemReq = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL rst_stall actual=%b required=0", MemStall); end
    checks++; if (MemRD !== 32'd0) begin errors++; $display("FAIL rst_rd actual=%h required=00000000", MemRD); end
    checks++; if (MemError !== 1'b0) begin errors++; $display("FAIL rst_err actual=%b required=0", MemError); end
`ifdef DMEM_ACCESS_COUNT_EN
    checks++; if (RdCount !== 0 || WrCount !== 0) begin errors++; $display("FAIL rst_counts actual=%0d/%0d required=0/0", RdCount, WrCount); end
`endif
    MemReq = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK); #1;
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL idle_stall actual=%b required=0", MemStall); end
  endtask

  task automatic test_word();
    bit [31:0] rd; bit err, leak; int st;
    access(1, 3'd2, 32'h10, 32'hDEADBEEF, 1, rd, err, st, leak);
    model_commit(1, 3'd2, 32'h10, 32'hDEADBEEF);
    checks++; if (st !== LAT) begin errors++; $display("FAIL sw_stall actual=%0d required=%0d", st, LAT); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_err actual=%b required=0", err); end
    access(0, 3'd2, 32'h10, 32'h0, 1, rd, err, st, leak);
    model_commit(0, 3'd2, 32'h10, 32'h0);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data actual=%h required=deadbeef", rd); end
    checks++; if (st !== LAT || err !== 1'b0 || leak) begin errors++; $display("FAIL lw_handshake actual=st%0d err%b leak%b required=st%0d err0 leak0", st, err, leak, LAT); end
    @(negedge CLK); #1;
    checks++; if (MemRD !== 32'd0) begin errors++; $display("FAIL rd_after_resp actual=%h required=00000000", MemRD); end
  endtask

  task automatic test_byte_half();
    bit [31:0] rd; bit err, leak; int st;
    bit [2:0]  sz [6] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5, 3'd1};
    bit [31:0] ad [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h11};
    bit [31:0] ex [6] = '{32'hDEAD55EF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'h0};
    bit        ee [6] = '{0, 0, 0, 0, 0, 1};
    access(1, 3'd0, 32'h11, 32'hAAAAAA55, 1, rd, err, st, leak);
    model_commit(1, 3'd0, 32'h11, 32'hAAAAAA55);
    for (int k = 0; k < 6; k++) begin
      access(0, sz[k], ad[k], 32'h0, 1, rd, err, st, leak);
      model_commit(0, sz[k], ad[k], 32'h0);
      checks++;
      if (rd !== ex[k] || err !== ee[k]) begin
        errors++;
        $display("FAIL load_fmt%0d actual=%h err%b required=%h err%b", k, rd, err, ex[k], ee[k]);
      end
    end
  endtask

  task automatic test_errors();
    bit [31:0] rd; bit err, leak; int st;
    bit        we [6] = '{1, 1, 1, 0, 0, 0};
    bit [2:0]  sz [6] = '{3'd2, 3'd2, 3'd4, 3'd3, 3'd6, 3'd2};
    bit [31:0] ad [6] = '{32'h12, 32'h1000, 32'h10, 32'h10, 32'h10, 32'h11};
    for (int k = 0; k < 6; k++) begin
      access(we[k], sz[k], ad[k], 32'h00000001, 1, rd, err, st, leak);
      checks++;
      if (err !== 1'b1 || rd !== 32'd0 || st !== LAT) begin
        errors++;
        $display("FAIL reject%0d actual=err%b rd%h st%0d required=err1 rd00000000 st%0d", k, err, rd, st, LAT);
      end
    end
    @(negedge CLK); #1;
    checks++; if (MemError !== 1'b0) begin errors++; $display("FAIL err_pulse actual=%b required=0", MemError); end
    access(0, 3'd2, 32'h10, 32'h0, 1, rd, err, st, leak);
    checks++; if (rd !== 32'hDEAD55EF || err !== 1'b0) begin errors++; $display("FAIL no_write_on_err actual=%h required=dead55ef", rd); end
  endtask

  task automatic test_back_to_back();
    bit [31:0] rd; bit err, leak; int st;
    access(1, 3'd2, 32'h24, 32'h11111111, 0, rd, err, st, leak);
    model_commit(1, 3'd2, 32'h24, 32'h11111111);
    access(1, 3'd0, 32'h24, 32'h000000AB, 0, rd, err, st, leak);
    model_commit(1, 3'd0, 32'h24, 32'h000000AB);
    checks++; if (st !== LAT) begin errors++; $display("FAIL b2b_restall actual=%0d required=%0d", st, LAT); end
    access(0, 3'd2, 32'h24, 32'h0, 0, rd, err, st, leak);
    model_commit(0, 3'd2, 32'h24, 32'h0);
    checks++; if (rd !== 32'h111111AB) begin errors++; $display("FAIL b2b_merge actual=%h required=111111ab", rd); end
    access(0, 3'd2, 32'h24, 32'h0, 1, rd, err, st, leak);
    model_commit(0, 3'd2, 32'h24, 32'h0);
    checks++; if (rd !== 32'h111111AB || st !== LAT) begin errors++; $display("FAIL b2b_repeat actual=%h st%0d required=111111ab st%0d", rd, st, LAT); end
  endtask

  task automatic test_random();
    bit [31:0] rd, a, wd, exp; bit err, leak, we, ee; bit [2:0] sz; int st;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      access(1, 3'd2, 32'(4 * w), wd, 1, rd, err, st, leak);
      model_commit(1, 3'd2, 32'(4 * w), wd);
    end
    for (int k = 0; k < 80; k++) begin
      we = 1'($urandom % 2);
      sz = 3'($urandom % 8);
      a = $urandom % 64;
      if ($urandom % 8 == 0) a = a | (32'h1000 << ($urandom % 20));
      wd = $urandom;
      ee = exp_err(we, sz, a);
      exp = (ee || we) ? 32'd0 : exp_load(sz, a);
      access(we, sz, a, wd, 1, rd, err, st, leak);
      model_commit(we, sz, a, wd);
      checks++;
      if (rd !== exp || err !== ee || st !== LAT || leak) begin
        errors++;
        $display("FAIL rand%0d we%b sz%0d a=%h actual=%h err%b st%0d leak%b required=%h err%b st%0d",
                 k, we, sz, a, rd, err, st, leak, exp, ee, LAT);
      end
    end
`ifdef DMEM_ACCESS_COUNT_EN
    @(negedge CLK); #1;
    checks++;
    if (RdCount !== 32'(n_rd) || WrCount !== 32'(n_wr)) begin
      errors++;
      $display("FAIL rand_counts actual=%0d/%0d required=%0d/%0d", RdCount, WrCount, n_rd, n_wr);
    end
`endif
  endtask

  task automatic test_reset_abort();
    bit [31:0] rd; bit err, leak; int st;
    access(1, 3'd2, 32'h20, 32'hCAFEF00D, 1, rd, err, st, leak);
    @(negedge CLK);
    MemReq = 1'b1; MemWE = 1'b1; MemSize = 3'd2; MemA = 32'h20; MemWD = 32'h12345678;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL abort_stall actual=%b required=0", MemStall); end
    @(negedge CLK);
    MemReq = 1'b0;
    @(negedge CLK);
`ifdef DMEM_ACCESS_COUNT_EN
    checks++; if (RdCount !== 0 || WrCount !== 0) begin errors++; $display("FAIL abort_counts actual=%0d/%0d required=0/0", RdCount, WrCount); end
`endif
    RESET = 1'b1;
    access(0, 3'd2, 32'h20, 32'h0, 1, rd, err, st, leak);
    checks++; if (rd !== 32'hCAFEF00D || err !== 1'b0) begin errors++; $display("FAIL abort_ram actual=%h required=cafef00d", rd); end
`ifdef DMEM_ACCESS_COUNT_EN
    @(negedge CLK); #1;
    checks++; if (RdCount !== 1 || WrCount !== 0) begin errors++; $display("FAIL post_abort_counts actual=%0d/%0d required=1/0", RdCount, WrCount); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
